// File: rtl/matriz_pkg.sv
// Shared types and constants for the 5x5 byte-matrix sequencer.
// Rows are 5 bytes packed little-end first; matrices are 5 rows packed likewise.
package matriz_pkg;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int ROW_W  = DIM * ELEM_W;
  localparam int MAT_W  = DIM * ROW_W;

  localparam logic [3:0] OP_SOMA   = 4'b0011;
  localparam logic [3:0] OP_SUB    = 4'b0100;
  localparam logic [3:0] OP_MULT   = 4'b0101;
  localparam logic [3:0] OP_TRANSP = 4'b0110;

  localparam logic [7:0] WDOG_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    READ_A,
    READ_B,
    EXEC,
    WAIT_CLR,
    WRITE_C
  } state_t;

  // Only the two-operand opcodes fetch a second matrix.
  function automatic logic needs_b(input logic [3:0] op);
    return (op == OP_SOMA) || (op == OP_SUB) || (op == OP_MULT);
  endfunction

endpackage

// File: rtl/matriz_sequenciador_if.sv
// Instruction, row-memory and ALU signals between the sequencer (master) and its environment.
// Instruction side is valid/ready; memory has a 1-cycle read latency; ALU is start/done.
interface matriz_sequenciador_if;
  import matriz_pkg::*;

  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       instr_opcode;
  logic [7:0]       instr_addr_a;
  logic [7:0]       instr_addr_b;
  logic [7:0]       instr_addr_c;

  logic [7:0]       mem_addr;
  logic             mem_rd_en;
  logic [ROW_W-1:0] mem_rdata;
  logic             mem_wr_en;
  logic [ROW_W-1:0] mem_wdata;

  logic [3:0]       alu_opcode;
  logic [MAT_W-1:0] alu_matriz_a;
  logic [MAT_W-1:0] alu_matriz_b;
  logic             alu_start;
  logic [MAT_W-1:0] alu_result;
  logic             alu_done;

  modport master (
    input  instr_valid, instr_opcode, instr_addr_a, instr_addr_b, instr_addr_c,
    output instr_ready,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata,
    output alu_opcode, alu_matriz_a, alu_matriz_b, alu_start,
    input  alu_result, alu_done
  );

  modport slave (
    output instr_valid, instr_opcode, instr_addr_a, instr_addr_b, instr_addr_c,
    input  instr_ready,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata,
    input  alu_opcode, alu_matriz_a, alu_matriz_b, alu_start,
    output alu_result, alu_done
  );

endinterface

// File: rtl/matriz_sequenciador.sv
// Sequencer: fetch A (and B) rows, run the ALU, write C rows back; one instruction at a time.
// Accepts only in IDLE (no queueing); ALU handshake is start/done with watchdog abort.
module matriz_sequenciador
  import matriz_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  matriz_sequenciador_if.master bus,
  output logic                  busy,
  output logic                  op_done,
  output logic                  op_error
);

  localparam logic [2:0] ROW_LAST = 3'(DIM - 1);
  localparam logic [2:0] CAP_LAST = 3'(DIM);

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic [3:0]       opcode_q;
  logic [7:0]       addr_a_q, addr_b_q, addr_c_q;
  logic [MAT_W-1:0] mat_a, mat_b, result_q;
  logic [7:0]       wdog;
  logic             err_q;
  logic             rd_pend;
  logic [2:0]       rd_row;
  logic             rd_is_b;
  logic             accept;
  logic             timeout;

  assign accept  = (state == IDLE) && bus.instr_valid;
  assign timeout = (state == EXEC) && !bus.alu_done && (wdog == WDOG_MAX - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (bus.instr_valid) state_nxt = READ_A;
      // The extra count step after the fifth read lets the last row land before moving on.
      READ_A:   if (cnt == CAP_LAST) state_nxt = needs_b(opcode_q) ? READ_B : EXEC;
      READ_B:   if (cnt == CAP_LAST) state_nxt = EXEC;
      EXEC:     if (bus.alu_done || timeout) state_nxt = WAIT_CLR;
      WAIT_CLR: if (!bus.alu_done) state_nxt = err_q ? IDLE : WRITE_C;
      WRITE_C:  if (cnt == ROW_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = 1'b0;
    busy            = 1'b1;
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.alu_start   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        busy            = 1'b0;
      end
      READ_A: if (cnt <= ROW_LAST) begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = addr_a_q + {5'd0, cnt};
      end
      READ_B: if (cnt <= ROW_LAST) begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = addr_b_q + {5'd0, cnt};
      end
      EXEC: bus.alu_start = 1'b1;
      WRITE_C: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = addr_c_q + {5'd0, cnt};
        bus.mem_wdata = result_q[int'(cnt) * ROW_W +: ROW_W];
      end
      default: ;
    endcase
  end

  assign bus.alu_opcode   = opcode_q;
  assign bus.alu_matriz_a = mat_a;
  assign bus.alu_matriz_b = mat_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      opcode_q <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
      mat_a    <= '0;
      mat_b    <= '0;
      result_q <= '0;
      wdog     <= '0;
      err_q    <= 1'b0;
      rd_pend  <= 1'b0;
      rd_row   <= '0;
      rd_is_b  <= 1'b0;
      op_done  <= 1'b0;
      op_error <= 1'b0;
    end else begin
      op_done  <= 1'b0;
      op_error <= 1'b0;

      if (state_nxt != state)
        cnt <= '0;
      else if (state == READ_A || state == READ_B || state == WRITE_C)
        cnt <= cnt + 3'd1;

      if (accept) begin
        opcode_q <= bus.instr_opcode;
        addr_a_q <= bus.instr_addr_a;
        addr_b_q <= bus.instr_addr_b;
        addr_c_q <= bus.instr_addr_c;
        mat_b    <= '0;
        err_q    <= 1'b0;
      end

      rd_pend <= bus.mem_rd_en;
      rd_row  <= cnt;
      rd_is_b <= (state == READ_B);
      if (rd_pend) begin
        if (rd_is_b) mat_b[int'(rd_row) * ROW_W +: ROW_W] <= bus.mem_rdata;
        else         mat_a[int'(rd_row) * ROW_W +: ROW_W] <= bus.mem_rdata;
      end

      if (state_nxt == EXEC && state != EXEC)
        wdog <= '0;
      else if (state == EXEC)
        wdog <= wdog + 8'd1;

      if (state == EXEC && bus.alu_done)
        result_q <= bus.alu_result;

      if (timeout) begin
        err_q    <= 1'b1;
        op_error <= 1'b1;
      end

      if (state == WRITE_C && cnt == ROW_LAST)
        op_done <= 1'b1;
    end
  end

endmodule
